// File: rtl/fifo_ram_controller_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_ram_controller_pkg: shared constants and wrap-bit pointer comparisons.
// Revision 1.0
// ----------------------------------------------------------------------------
package fifo_ram_controller_pkg;

  localparam int DEFAULT_WIDTH                  = 8;
  localparam int DEFAULT_DEPTH                  = 16;
  localparam int DEFAULT_ADDRESS_WIDTH          = $clog2(DEFAULT_DEPTH);
  localparam int DEFAULT_ALMOST_FULL_THRESHOLD  = DEFAULT_DEPTH - 2;
  localparam int DEFAULT_ALMOST_EMPTY_THRESHOLD = 2;
  localparam int PTR_MAX_WIDTH                  = 32;

  typedef logic [PTR_MAX_WIDTH-1:0] ptr_t;

  // One extra bit holds 0..DEPTH, and also DEPTH+1 because DEPTH is a power of two.
  function automatic int level_width(input int address_width);
    return address_width + 1;
  endfunction

  localparam int LEVEL_WIDTH = level_width(DEFAULT_ADDRESS_WIDTH);

  function automatic logic is_empty(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return wr_ptr == rd_ptr;
  endfunction

  function automatic logic is_full(input ptr_t wr_ptr, input ptr_t rd_ptr,
                                   input int unsigned address_width);
    return (wr_ptr ^ rd_ptr) == (ptr_t'(1) << address_width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_ram_controller_if: producer, consumer, RAM-port and status signals.
// Revision 1.0
// ----------------------------------------------------------------------------
interface fifo_ram_controller_if #(
  parameter int WIDTH         = fifo_ram_controller_pkg::DEFAULT_WIDTH,
  parameter int ADDRESS_WIDTH = fifo_ram_controller_pkg::DEFAULT_ADDRESS_WIDTH
);
  logic                     write_valid;
  logic [WIDTH-1:0]         write_data;
  logic                     write_ready;
  logic                     read_valid;
  logic [WIDTH-1:0]         read_data;
  logic                     read_ready;
  logic                     ram_write_enable;
  logic [ADDRESS_WIDTH-1:0] ram_write_address;
  logic [WIDTH-1:0]         ram_write_data;
  logic                     ram_read_enable;
  logic [ADDRESS_WIDTH-1:0] ram_read_address;
  logic [WIDTH-1:0]         ram_read_data;
  logic [ADDRESS_WIDTH:0]   level;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;

  modport slave (
    input  write_valid, write_data, read_ready, ram_read_data,
    output write_ready, read_valid, read_data,
    output ram_write_enable, ram_write_address, ram_write_data,
    output ram_read_enable, ram_read_address,
    output level, full, empty, almost_full, almost_empty
  );

  modport master (
    output write_valid, write_data, read_ready, ram_read_data,
    input  write_ready, read_valid, read_data,
    input  ram_write_enable, ram_write_address, ram_write_data,
    input  ram_read_enable, ram_read_address,
    input  level, full, empty, almost_full, almost_empty
  );
endinterface
`default_nettype wire

// File: rtl/fifo_ram_controller_pointer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_pointer: wrap-bit counter with increment enable and async reset.
// Revision 1.0
// ----------------------------------------------------------------------------
module fifo_pointer #(
  parameter int PTR_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 increment_i,
  output logic [PTR_WIDTH-1:0] pointer_o,
  output logic [PTR_WIDTH-1:0] pointer_next_o
);
  logic [PTR_WIDTH-1:0] pointer_q;
  logic [PTR_WIDTH-1:0] pointer_d;

  always_comb begin
    pointer_d = pointer_q + PTR_WIDTH'(increment_i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pointer_q <= '0;
    end else begin
      pointer_q <= pointer_d;
    end
  end

  assign pointer_o      = pointer_q;
  assign pointer_next_o = pointer_d;
endmodule
`default_nettype wire

// File: rtl/fifo_ram_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_ram_controller: FIFO pointers/flags driving a dual-port RAM; optional
// output register via FIFO_RAM_CONTROLLER_OUTPUT_REGISTER_EN.  Revision 1.0
// ----------------------------------------------------------------------------
module fifo_ram_controller
  import fifo_ram_controller_pkg::*;
#(
  parameter int WIDTH                  = DEFAULT_WIDTH,
  parameter int DEPTH                  = DEFAULT_DEPTH,
  parameter int ADDRESS_WIDTH          = $clog2(DEPTH),
  parameter int ALMOST_FULL_THRESHOLD  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = DEFAULT_ALMOST_EMPTY_THRESHOLD
) (
  input  logic                   clock,
  input  logic                   reset,
  fifo_ram_controller_if.slave   bus
);
  localparam int            LW       = level_width(ADDRESS_WIDTH);
  localparam logic [LW-1:0] AF_LEVEL = LW'(ALMOST_FULL_THRESHOLD);
  localparam logic [LW-1:0] AE_LEVEL = LW'(ALMOST_EMPTY_THRESHOLD);

  logic [LW-1:0] wr_ptr, wr_ptr_next, rd_ptr, rd_ptr_next;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
  logic          write_accept, read_pop, ram_pop;

  // Reset is folded in so no RAM write strobe escapes while reset is held.
  assign write_accept = bus.write_valid & ~full_q & ~reset;

  fifo_pointer #(.PTR_WIDTH(LW)) u_wr_ptr (
    .clock          (clock),
    .reset          (reset),
    .increment_i    (write_accept),
    .pointer_o      (wr_ptr),
    .pointer_next_o (wr_ptr_next)
  );

  fifo_pointer #(.PTR_WIDTH(LW)) u_rd_ptr (
    .clock          (clock),
    .reset          (reset),
    .increment_i    (ram_pop),
    .pointer_o      (rd_ptr),
    .pointer_next_o (rd_ptr_next)
  );

`ifdef FIFO_RAM_CONTROLLER_OUTPUT_REGISTER_EN
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q, out_valid_d;
  logic             ram_empty;

  // The register refills from the RAM whenever it is free or being drained.
  assign ram_empty   = is_empty(ptr_t'(wr_ptr), ptr_t'(rd_ptr));
  assign read_pop    = out_valid_q & bus.read_ready;
  assign ram_pop     = ~ram_empty & (~out_valid_q | read_pop);
  assign out_valid_d = ram_pop | (out_valid_q & ~read_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (ram_pop) begin
        out_data_q <= bus.ram_read_data;
      end
    end
  end

  assign bus.read_valid      = out_valid_q;
  assign bus.read_data       = out_data_q;
  assign bus.ram_read_enable = ram_pop;
  assign full_d  = is_full(ptr_t'(wr_ptr_next), ptr_t'(rd_ptr_next), ADDRESS_WIDTH) & out_valid_d;
  assign empty_d = is_empty(ptr_t'(wr_ptr_next), ptr_t'(rd_ptr_next)) & ~out_valid_d;
`else
  assign read_pop            = ~empty_q & bus.read_ready;
  assign ram_pop             = read_pop;
  assign bus.read_valid      = ~empty_q;
  assign bus.read_data       = bus.ram_read_data;
  assign bus.ram_read_enable = ~empty_q;
  assign full_d  = is_full(ptr_t'(wr_ptr_next), ptr_t'(rd_ptr_next), ADDRESS_WIDTH);
  assign empty_d = is_empty(ptr_t'(wr_ptr_next), ptr_t'(rd_ptr_next));
`endif

  always_comb begin
    level_d        = level_q + LW'(write_accept) - LW'(read_pop);
    almost_full_d  = (level_d >= AF_LEVEL);
    almost_empty_d = (level_d <= AE_LEVEL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      level_q        <= level_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign bus.write_ready       = ~full_q;
  assign bus.ram_write_enable  = write_accept;
  assign bus.ram_write_address = wr_ptr[ADDRESS_WIDTH-1:0];
  assign bus.ram_write_data    = bus.write_data;
  assign bus.ram_read_address  = rd_ptr[ADDRESS_WIDTH-1:0];
  assign bus.level             = level_q;
  assign bus.full              = full_q;
  assign bus.empty             = empty_q;
  assign bus.almost_full       = almost_full_q;
  assign bus.almost_empty      = almost_empty_q;
endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fifo_ram_controller: queue-model bench with an attached behavioural RAM.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_fifo_ram_controller;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;
`ifdef FIFO_RAM_CONTROLLER_OUTPUT_REGISTER_EN
  localparam int CAP  = DEPTH + 1;
  localparam bit OREG = 1'b1;
`else
  localparam int CAP  = DEPTH;
  localparam bit OREG = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  fifo_ram_controller_if #(.WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) bus ();

  fifo_ram_controller #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW),
    .ALMOST_FULL_THRESHOLD(AF), .ALMOST_EMPTY_THRESHOLD(AE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) if (bus.ram_write_enable) mem[bus.ram_write_address] <= bus.ram_write_data;
  assign bus.ram_read_data = mem[bus.ram_read_address];

  // Model: the FIFO is an ordered list of words; with the output register the
  // head becomes visible only once it has been moved out of the RAM.
  logic [WIDTH-1:0] q[$];
  bit               reg_valid = 1'b0;

  always @(posedge clock or posedge reset) begin : model
    bit wa, consume, load;
    int ram_count;
    if (reset) begin
      q.delete();
      reg_valid = 1'b0;
    end else begin
      wa = bus.write_valid && (q.size() < CAP);
      if (OREG) begin
        consume   = reg_valid && bus.read_ready;
        ram_count = q.size() - int'(reg_valid);
        load      = (ram_count > 0) && (!reg_valid || consume);
      end else begin
        consume = (q.size() > 0) && bus.read_ready;
        load    = consume;
      end
      if (consume) void'(q.pop_front());
      if (wa) q.push_back(bus.write_data);
      if (OREG) reg_valid = load || (reg_valid && !consume);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin : compare
    int n;
    bit rv, rden;
    n    = q.size();
    rv   = OREG ? reg_valid : (n > 0);
    rden = OREG ? ((n - int'(reg_valid) > 0) && (!reg_valid || bus.read_ready)) : (n > 0);
    chk("level",        32'(bus.level),            n);
    chk("full",         32'(bus.full),             32'(n == CAP));
    chk("empty",        32'(bus.empty),            32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),      32'(n >= AF));
    chk("almost_empty", 32'(bus.almost_empty),     32'(n <= AE));
    chk("write_ready",  32'(bus.write_ready),      32'(n < CAP));
    chk("read_valid",   32'(bus.read_valid),       32'(rv));
    chk("ram_wen",      32'(bus.ram_write_enable), 32'(bus.write_valid && n < CAP && !reset));
    chk("ram_ren",      32'(bus.ram_read_enable),  32'(rden));
    if (bus.ram_write_enable) chk("ram_wdata", 32'(bus.ram_write_data), 32'(bus.write_data));
    if (rv) chk("read_data", 32'(bus.read_data), 32'(q[0]));
  end

  task automatic step(input bit wv, input logic [WIDTH-1:0] wd, input bit rr);
    bus.write_valid = wv;
    bus.write_data  = wd;
    bus.read_ready  = rr;
    @(posedge clock);
    #2;
  endtask

  initial begin
    bus.write_valid = 1'b0;
    bus.write_data  = '0;
    bus.read_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_level",  32'(bus.level),            0);
    chk("rst_empty",  32'(bus.empty),            1);
    chk("rst_full",   32'(bus.full),             0);
    chk("rst_ae",     32'(bus.almost_empty),     1);
    chk("rst_af",     32'(bus.almost_full),      0);
    chk("rst_wready", 32'(bus.write_ready),      1);
    chk("rst_rvalid", 32'(bus.read_valid),       0);
    chk("rst_wen",    32'(bus.ram_write_enable), 0);
    reset = 1'b0;

    for (int i = 0; i < CAP; i++) begin
      step(1'b1, WIDTH'(i), 1'b0);
      if (i == 12) chk("af_at_13", 32'(bus.almost_full), 0);
      if (i == 13) chk("af_at_14", 32'(bus.almost_full), 1);
    end
    chk("fill_level",  32'(bus.level),       CAP);
    chk("fill_full",   32'(bus.full),        1);
    chk("fill_wready", 32'(bus.write_ready), 0);

    for (int i = 0; i < CAP; i++) begin
      chk("drain_data", 32'(bus.read_data), i);
      step(1'b0, '0, 1'b1);
      if (i == CAP - 4) chk("ae_at_3", 32'(bus.almost_empty), 0);
      if (i == CAP - 3) chk("ae_at_2", 32'(bus.almost_empty), 1);
    end
    chk("drain_empty",  32'(bus.empty),      1);
    chk("drain_rvalid", 32'(bus.read_valid), 0);

    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, WIDTH'(8'h50 + i), 1'b1);
    chk("stream_level", 32'(bus.level), 5);
    for (int i = 0; i < 5; i++) begin
      chk("stream_tail", 32'(bus.read_data), 8'h73 + i);
      step(1'b0, '0, 1'b1);
    end

    for (int i = 0; i < CAP; i++) step(1'b1, WIDTH'(8'h80 + i), 1'b0);
    bus.write_valid = 1'b1;
    bus.write_data  = 8'hE0;
    bus.read_ready  = 1'b1;
    #1;
    chk("full_rw_wen",    32'(bus.ram_write_enable), 0);
    chk("full_rw_wready", 32'(bus.write_ready),      0);
    @(posedge clock);
    #2;
    chk("full_rw_level", 32'(bus.level), CAP - 1);
    step(1'b1, 8'hE0, 1'b0);
    chk("retry_level", 32'(bus.level), CAP);

    repeat (CAP - 7) step(1'b0, '0, 1'b1);
    chk("pre_rst_level", 32'(bus.level), 7);
    bus.write_valid = 1'b1;
    bus.write_data  = 8'h11;
    bus.read_ready  = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_level",  32'(bus.level),            0);
    chk("mid_rst_empty",  32'(bus.empty),            1);
    chk("mid_rst_rvalid", 32'(bus.read_valid),       0);
    chk("mid_rst_wen",    32'(bus.ram_write_enable), 0);
    @(posedge clock);
    #2;
    bus.write_valid = 1'b0;
    bus.read_ready  = 1'b0;
    reset = 1'b0;
    chk("post_rst_level", 32'(bus.level), 0);

    step(1'b1, 8'h3C, 1'b0);
    bus.write_valid = 1'b0;
`ifdef FIFO_RAM_CONTROLLER_OUTPUT_REGISTER_EN
    chk("lat_cycle1", 32'(bus.read_valid), 0);
    step(1'b0, '0, 1'b0);
    chk("lat_cycle2", 32'(bus.read_valid), 1);
`else
    chk("lat_cycle1", 32'(bus.read_valid), 1);
`endif
    chk("lat_data", 32'(bus.read_data), 8'h3C);
    step(1'b0, '0, 1'b1);

    step(1'b1, 8'hA5, 1'b0);
    bus.write_valid = 1'b0;
    for (int k = 0; k < 4 && !bus.read_valid; k++) step(1'b0, '0, 1'b0);
    chk("a5_valid", 32'(bus.read_valid), 1);
    chk("a5_data",  32'(bus.read_data),  8'hA5);
    step(1'b0, '0, 1'b1);
    chk("final_empty", 32'(bus.empty), 1);

    @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
